// File: rtl/key_param_ctrl_pkg.sv
// key_pkg: shared state encoding and timing constants for the key parameter editor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package key_pkg;

  // Edit FSM states
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Core clock frequency the default timeout is derived from
  localparam int unsigned CLK_HZ          = 100_000_000;
  localparam int unsigned TIMEOUT_SEC     = 5;
  localparam int unsigned TIMEOUT_CYC_DEF = CLK_HZ * TIMEOUT_SEC;

endpackage

// File: rtl/key_param_step.sv
// key_param_step: one increment/decrement by STEP with saturate or wrap at the limits.
// Latency: combinational.
// Backpressure: none; en_i=0 passes value_i through unchanged.
// Ports: value_i current value, dir_i 0=up 1=down, en_i apply step, result_o next value.
module key_param_step #(
  parameter int W       = 8,
  parameter int VAL_MIN = 0,
  parameter int VAL_MAX = 255,
  parameter int STEP    = 1,
  parameter int WRAP    = 0
) (
  input  logic [W-1:0] value_i,
  input  logic         dir_i,
  input  logic         en_i,
  output logic [W-1:0] result_o
);

  // One extra bit of headroom so limit checks never alias through modular overflow
  localparam logic [W:0] MIN_X  = (W+1)'(VAL_MIN);
  localparam logic [W:0] MAX_X  = (W+1)'(VAL_MAX);
  localparam logic [W:0] STEP_X = (W+1)'(STEP);
  localparam logic [W:0] DEC_LO = MIN_X + STEP_X;

  logic [W:0] val_x;
  logic [W:0] sum_x;
  logic [W:0] diff_x;

  assign val_x = {1'b0, value_i};

  always_comb begin
    result_o = value_i;
    sum_x    = val_x + STEP_X;
    diff_x   = val_x - STEP_X;
    if (en_i) begin
      if (!dir_i) begin
        if (sum_x > MAX_X) result_o = (WRAP != 0) ? MIN_X[W-1:0] : MAX_X[W-1:0];
        else               result_o = sum_x[W-1:0];
      end else begin
        // value < MIN+STEP means the subtraction would land below MIN
        if (val_x < DEC_LO) result_o = (WRAP != 0) ? MAX_X[W-1:0] : MIN_X[W-1:0];
        else                result_o = diff_x[W-1:0];
      end
    end
  end

endmodule

// File: rtl/key_param_ctrl.sv
// key_param_ctrl: key-driven edit of a config value, committed downstream on exit; idle timeout aborts.
// Latency: key pulse to edit_val/state 1 cycle; k0 to cfg_valid 1 cycle.
// Backpressure: holds cfg_valid/cfg_data until cfg_ready; keys dropped while waiting.
// Ports: clk, rst_n (async low); k0/k1/k2 key pulses; cfg_ready/cfg_valid/cfg_data commit
//        handshake; cur_val committed value; edit_val shadow value; editing; timeout_evt pulse.
module key_param_ctrl
  import key_pkg::*;
#(
  parameter int          W           = 8,
  parameter int          VAL_MIN     = 0,
  parameter int          VAL_MAX     = 255,
  parameter int          VAL_INIT    = 0,
  parameter int          STEP        = 1,
  parameter int          WRAP        = 0,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         k0,
  input  logic         k1,
  input  logic         k2,
  input  logic         cfg_ready,
  output logic         cfg_valid,
  output logic [W-1:0] cfg_data,
  output logic [W-1:0] cur_val,
  output logic [W-1:0] edit_val,
  output logic         editing,
  output logic         timeout_evt
);

  localparam int             CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [W-1:0]   INIT_V   = W'(VAL_INIT);

  state_t        state_q, state_d;
  logic [W-1:0]  edit_q, edit_d;
  logic [W-1:0]  cur_q, cur_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tevt_q, tevt_d;

  logic          step_en, step_dir;
  logic [W-1:0]  step_val;

  key_param_step #(
    .W(W), .VAL_MIN(VAL_MIN), .VAL_MAX(VAL_MAX), .STEP(STEP), .WRAP(WRAP)
  ) u_step (
    .value_i  (edit_q),
    .dir_i    (step_dir),
    .en_i     (step_en),
    .result_o (step_val)
  );

  always_comb begin
    state_d  = state_q;
    edit_d   = edit_q;
    cur_d    = cur_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    tevt_d   = 1'b0;
    step_en  = 1'b0;
    step_dir = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (k0) begin
          state_d = ST_EDIT;
          edit_d  = cur_q;
          cnt_d   = '0;
        end
      end
      ST_EDIT: begin
        if (k0) begin
          cnt_d = '0;
          if (edit_q == cur_q) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_COMMIT;
            data_d  = edit_q;
          end
        end else if (k1 && k2) begin
          // Conflicting steps cancel, but still count as activity
          cnt_d = '0;
        end else if (k1 || k2) begin
          step_en  = 1'b1;
          step_dir = ~k1;
          edit_d   = step_val;
          cnt_d    = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          edit_d  = cur_q;
          tevt_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_COMMIT: begin
        if (cfg_ready) begin
          cur_d   = data_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      edit_q  <= INIT_V;
      cur_q   <= INIT_V;
      data_q  <= INIT_V;
      cnt_q   <= '0;
      tevt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      edit_q  <= edit_d;
      cur_q   <= cur_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      tevt_q  <= tevt_d;
    end
  end

  // Status outputs are decodes of the state register only
  assign cfg_valid   = (state_q == ST_COMMIT);
  assign editing     = (state_q == ST_EDIT);
  assign cfg_data    = data_q;
  assign cur_val     = cur_q;
  assign edit_val    = edit_q;
  assign timeout_evt = tevt_q;

endmodule

// File: tb/tb_key_param_ctrl.sv
module tb_key_param_ctrl;

  localparam logic [2:0] NK = 3'b000;
  localparam logic [2:0] K0 = 3'b001;
  localparam logic [2:0] K1 = 3'b010;
  localparam logic [2:0] K2 = 3'b100;

  logic clk = 1'b0;
  logic rst_n;
  logic k0_a, k1_a, k2_a, rdy_a;
  logic k0_b, k1_b, k2_b, rdy_b;
  logic       vld_a, ed_a, tevt_a;
  logic [7:0] dat_a, cur_a, edv_a;
  logic       vld_b, ed_b, tevt_b;
  logic [7:0] dat_b, cur_b, edv_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  key_param_ctrl #(
    .W(8), .VAL_MIN(0), .VAL_MAX(255), .VAL_INIT(10), .STEP(1), .WRAP(0), .TIMEOUT_CYC(100)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .k0(k0_a), .k1(k1_a), .k2(k2_a), .cfg_ready(rdy_a),
    .cfg_valid(vld_a), .cfg_data(dat_a), .cur_val(cur_a), .edit_val(edv_a),
    .editing(ed_a), .timeout_evt(tevt_a)
  );

  key_param_ctrl #(
    .W(8), .VAL_MIN(0), .VAL_MAX(255), .VAL_INIT(255), .STEP(1), .WRAP(1), .TIMEOUT_CYC(100)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .k0(k0_b), .k1(k1_b), .k2(k2_b), .cfg_ready(rdy_b),
    .cfg_valid(vld_b), .cfg_data(dat_b), .cur_val(cur_b), .edit_val(edv_b),
    .editing(ed_b), .timeout_evt(tevt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present keys for exactly one rising edge, then return 1 time unit after it
  task automatic cyc(input logic [2:0] ka, input logic [2:0] kb);
    @(negedge clk);
    {k2_a, k1_a, k0_a} = ka;
    {k2_b, k1_b, k0_b} = kb;
    @(posedge clk);
    #1;
    {k2_a, k1_a, k0_a} = 3'b000;
    {k2_b, k1_b, k0_b} = 3'b000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(NK, NK);
  endtask

  initial begin
    rst_n = 1'b1;
    {k2_a, k1_a, k0_a} = 3'b000;
    {k2_b, k1_b, k0_b} = 3'b000;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_cur_a",   cur_a, 10);
    chk("rst_edit_a",  edv_a, 10);
    chk("rst_data_a",  dat_a, 10);
    chk("rst_vld_a",   vld_a, 0);
    chk("rst_edit_st", ed_a, 0);
    chk("rst_tevt_a",  tevt_a, 0);
    chk("rst_cur_b",   cur_b, 255);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic edit and commit with ready already high
    rdy_a = 1'b1;
    cyc(K0, NK);
    chk("t1_editing", ed_a, 1);
    chk("t1_edit_ld", edv_a, 10);
    for (int i = 0; i < 3; i++) cyc(K1, NK);
    chk("t1_edit13", edv_a, 13);
    cyc(K0, NK);
    chk("t1_vld",     vld_a, 1);
    chk("t1_data",    dat_a, 13);
    chk("t1_ed_drop", ed_a, 0);
    chk("t1_cur_old", cur_a, 10);
    idle(1);
    chk("t1_vld_off", vld_a, 0);
    chk("t1_cur13",   cur_a, 13);
    rdy_a = 1'b0;

    // Net-zero edit returns without a handshake
    cyc(K0, NK); cyc(K1, NK); cyc(K2, NK); cyc(K0, NK);
    chk("t3_vld",  vld_a, 0);
    chk("t3_ed",   ed_a, 0);
    idle(2);
    chk("t3_vld2", vld_a, 0);
    chk("t3_cur",  cur_a, 13);

    // k0 and k1 together act as k0 alone
    cyc(K0, NK);
    cyc(K0 | K1, NK);
    chk("t6_ed",   ed_a, 0);
    chk("t6_edit", edv_a, 13);
    chk("t6_vld",  vld_a, 0);

    // Saturation at both limits
    cyc(K0, NK);
    for (int i = 0; i < 20; i++) cyc(K2, NK);
    chk("t2_sat_lo", edv_a, 0);
    for (int i = 0; i < 300; i++) cyc(K1, NK);
    chk("t2_sat_hi", edv_a, 255);
    cyc(K1, NK);
    chk("t2_sat_hi2", edv_a, 255);

    // Commit stalled by ready low; keys are dropped meanwhile
    cyc(K0, NK);
    chk("t5_vld", vld_a, 1);
    for (int i = 0; i < 20; i++) begin
      cyc((i % 3 == 0) ? K0 : ((i % 3 == 1) ? K1 : K2), NK);
      chk("t5_hold_vld",  vld_a, 1);
      chk("t5_hold_data", dat_a, 255);
    end
    chk("t5_cur_old", cur_a, 13);
    chk("t5_edit",    edv_a, 255);
    rdy_a = 1'b1;
    idle(1);
    chk("t5_cur_new", cur_a, 255);
    chk("t5_vld_off", vld_a, 0);
    rdy_a = 1'b0;

    // Wrap-around on the second instance
    cyc(NK, K0);
    chk("t2w_ed",   ed_b, 1);
    cyc(NK, K1);
    chk("t2w_up",   edv_b, 0);
    cyc(NK, K2);
    chk("t2w_down", edv_b, 255);
    cyc(NK, K0);
    chk("t2w_exit", ed_b, 0);
    chk("t2w_vld",  vld_b, 0);

    // Inactivity timeout
    cyc(K0, NK);
    cyc(K2, NK);
    chk("t4_edit254", edv_a, 254);
    idle(99);
    chk("t4_no_evt", tevt_a, 0);
    chk("t4_still",  ed_a, 1);
    idle(1);
    chk("t4_evt",    tevt_a, 1);
    chk("t4_ed_off", ed_a, 0);
    chk("t4_revert", edv_a, 255);
    chk("t4_vld",    vld_a, 0);
    idle(1);
    chk("t4_evt_1c", tevt_a, 0);

    // A key on the last count cycle restarts the count
    cyc(K0, NK);
    cyc(K2, NK);
    idle(99);
    cyc(K2, NK);
    chk("t4r_no_evt", tevt_a, 0);
    chk("t4r_edit",   edv_a, 253);
    idle(99);
    chk("t4r_still",  ed_a, 1);
    idle(1);
    chk("t4r_evt",    tevt_a, 1);
    chk("t4r_revert", edv_a, 255);

    // Reset in the middle of a commit
    cyc(K0, NK);
    cyc(K2, NK);
    cyc(K0, NK);
    chk("t6r_vld_pre", vld_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6r_vld",  vld_a, 0);
    chk("t6r_cur",  cur_a, 10);
    chk("t6r_edit", edv_a, 10);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("t6r_vld_after", vld_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_param_ctrl.md
Name: key_param_ctrl

Overview:
- Consumes the single-cycle key pulses k0/k1/k2 from the key debouncer.
- Runs a small edit FSM: k0 enters and leaves edit mode, k1 increments a shadow value, k2 decrements it.
- On exit, any changed value is committed to the downstream datapath (backscatter configuration) through a valid/ready handshake.
- An edit-mode inactivity timeout discards uncommitted edits.

Parameters:
- W, 8, width of the configuration value.
- VAL_MIN, 0, lowest legal value.
- VAL_MAX, 255, highest legal value.
- VAL_INIT, 0, committed value after reset; must lie in [VAL_MIN, VAL_MAX].
- STEP, 1, increment/decrement amount per key pulse; must be at least 1.
- WRAP, 0, 0 = saturate at the limits, 1 = wrap around (VAL_MAX+step goes to VAL_MIN and vice versa).
- TIMEOUT_CYC, 500_000_000, clk cycles of key inactivity in EDIT before abort (5 s at 100 MHz); counter width is $clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- k0  in  1  single-cycle pulse: toggle edit mode / request commit.
- k1  in  1  single-cycle pulse: increment.
- k2  in  1  single-cycle pulse: decrement.
- cfg_ready  in  1  downstream accepts cfg_data.
- cfg_valid  out  1  commit request.
- cfg_data  out  W  value being committed; stable while cfg_valid=1.
- cur_val  out  W  last committed (accepted) value.
- edit_val  out  W  shadow value being edited; used for display.
- editing  out  1  high in EDIT state.
- timeout_evt  out  1  one-cycle pulse when an edit is aborted by timeout.

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN; cur_val=edit_val=cfg_data=VAL_INIT.
  - cfg_valid=0, editing=0, timeout_evt=0, timeout counter=0.
  - All outputs are registered; no combinational path from inputs to outputs.
- States: RUN, EDIT, COMMIT.
- RUN:
  - k1/k2 are ignored.
  - k0 -> EDIT next cycle; edit_val<=cur_val; counter cleared.
- EDIT (editing=1):
  - Key priority on the same cycle: k0 > k1 > k2.
  - k1&k2 together without k0: no change, but the counter is cleared.
  - k1: edit_val += STEP; above VAL_MAX -> VAL_MAX (WRAP=0) or VAL_MIN (WRAP=1).
  - k2: edit_val -= STEP; below VAL_MIN -> VAL_MIN (WRAP=0) or VAL_MAX (WRAP=1).
  - Limit checks use W+1-bit arithmetic so no modular overflow is possible.
  - Any key pulse clears the counter; otherwise it increments each cycle.
  - k0 with edit_val==cur_val: back to RUN, no handshake.
  - k0 with edit_val!=cur_val: enter COMMIT; cfg_data<=edit_val; cfg_valid<=1 next cycle.
  - Counter reaching TIMEOUT_CYC-1 with no key that cycle: back to RUN; edit_val<=cur_val; timeout_evt=1 for one cycle.
- COMMIT:
  - cfg_valid=1 and cfg_data held until the cycle with cfg_ready=1.
  - On that cycle: cur_val<=cfg_data; cfg_valid<=0; state<=RUN.
  - All key pulses are ignored (dropped) in COMMIT; no timeout applies.
  - cfg_ready already high on the first valid cycle: one-cycle handshake.
  - cfg_ready while cfg_valid=0 has no effect.
- Latency:
  - Key pulse to edit_val/state update: 1 cycle.
  - k0 to cfg_valid: 1 cycle.
- Reset mid-COMMIT: cfg_valid drops immediately and the pending value is lost; cur_val=VAL_INIT.

Decomposition:
- Shared package key_pkg holds:
  - state enum (RUN/EDIT/COMMIT);
  - default TIMEOUT_CYC;
  - the clk-frequency constant used to derive it.
- One natural sub-module: key_param_step, a combinational increment/decrement with saturate/wrap (inputs value, dir, en; parameters W, VAL_MIN, VAL_MAX, STEP, WRAP).
- The FSM, timeout counter and handshake stay in the top.

Test Plan:
1. Reset with VAL_INIT=10, then k0, k1×3, k0, cfg_ready=1 -> cfg_valid 1 cycle after the second k0 with cfg_data=13; cur_val=13 after the handshake; editing drops.
2. WRAP=0: edit from cur_val=254, k1×3 -> edit_val 255 (stays 255); k2 at VAL_MIN=0 stays 0. WRAP=1: 255+k1 -> 0, 0+k2 -> 255.
3. k0, k1, k2, k0 (net unchanged) -> cfg_valid never asserts; state returns to RUN.
4. TIMEOUT_CYC=100: k0, k1, then idle 100 cycles -> timeout_evt pulse; edit_val reverts to cur_val; cfg_valid stays 0. A k1 at cycle 99 restarts the count.
5. Commit with cfg_ready=0 for 20 cycles while pulsing k0/k1/k2 -> cfg_valid and cfg_data stable, keys ignored. cfg_ready=1 -> cur_val updates the same edge, cfg_valid=0 the next cycle.
6. k0&k1 same cycle in EDIT -> treated as k0 only. Drop rst_n mid-COMMIT -> cfg_valid=0 asynchronously; cur_val=VAL_INIT.
